// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard receiver: frame check, E0/F0 prefix folding, modifier tracking
// and a show-ahead event FIFO. Optional macro: PS2_TYPEMATIC_FILTER_EN.
module ps2_keyboard_ctrl #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       evValid,
  input  logic       evReady,
  output logic [7:0] evCode,
  output logic       evExtended,
  output logic       evBreak,
  output logic       frameError,
  output logic       overflow,
  output logic       shift,
  output logic       ctrl,
  output logic       alt,
  output logic       debugE0,
  output logic       debugF0
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  function automatic logic oddParityOk(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  state_t          state_r, stateNext_s;
  logic            prevClk_r, fall_s, timeout_s, accept_s, err_s;
  logic [2:0]      bitCnt_r;
  logic [7:0]      dataSr_r, byte_r;
  logic            parBit_r, byteValid_r, frameErr_r;
  logic [TW-1:0]   toCnt_r;
  logic            pendE0_r, pendF0_r;
  logic            lShift_r, rShift_r, lCtrl_r, rCtrl_r, lAlt_r, rAlt_r;
  logic            lShiftNext_s, rShiftNext_s, lCtrlNext_s, rCtrlNext_s, lAltNext_s, rAltNext_s;
  logic            shift_r, ctrl_r, alt_r;
  logic            isE0_s, isF0_s, isKey_s, suppress_s, pushReq_s;
  logic [9:0]      mem_r [FIFO_DEPTH];
  logic [9:0]      pushData_s, headNext_s, head_r;
  logic [AW-1:0]   wrPtr_r, rdPtr_r, rdNext_s;
  logic [AW:0]     count_r, countNext_s;
  logic            evValid_r, overflow_r, pop_s, full_s, pushOk_s, ovfSet_s;

  assign fall_s    = prevClk_r & ~ps2Clk;
  assign timeout_s = (state_r != IDLE) && !fall_s && (toCnt_r == TO_LAST);

  // Frame FSM next state; an expired timeout aborts any partial frame
  always_comb begin
    stateNext_s = state_r;
    accept_s    = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s && !ps2Data) stateNext_s = DATA;
        else                    stateNext_s = IDLE;
      end
      DATA: begin
        if (fall_s) stateNext_s = (bitCnt_r == 3'd7) ? PARITY : DATA;
        else if (timeout_s) begin stateNext_s = IDLE; err_s = 1'b1; end
        else stateNext_s = DATA;
      end
      PARITY: begin
        if (fall_s) stateNext_s = STOP;
        else if (timeout_s) begin stateNext_s = IDLE; err_s = 1'b1; end
        else stateNext_s = PARITY;
      end
      STOP: begin
        if (fall_s) begin
          stateNext_s = IDLE;
          if (ps2Data && oddParityOk(dataSr_r, parBit_r)) accept_s = 1'b1;
          else                                            err_s    = 1'b1;
        end else if (timeout_s) begin
          stateNext_s = IDLE;
          err_s       = 1'b1;
        end else begin
          stateNext_s = STOP;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Frame state, bit shifter and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      prevClk_r   <= 1'b0;
      bitCnt_r    <= 3'd0;
      dataSr_r    <= 8'd0;
      parBit_r    <= 1'b0;
      toCnt_r     <= '0;
      byteValid_r <= 1'b0;
      byte_r      <= 8'd0;
      frameErr_r  <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      prevClk_r   <= ps2Clk;
      byteValid_r <= accept_s;
      frameErr_r  <= err_s;
      if (state_r == IDLE)              bitCnt_r <= 3'd0;
      else if (state_r == DATA && fall_s) bitCnt_r <= bitCnt_r + 3'd1;
      if (state_r == DATA && fall_s)    dataSr_r <= {ps2Data, dataSr_r[7:1]};
      if (state_r == PARITY && fall_s)  parBit_r <= ps2Data;
      if (state_r == IDLE || fall_s)    toCnt_r  <= '0;
      else                              toCnt_r  <= toCnt_r + TW'(1);
      if (accept_s)                     byte_r   <= dataSr_r;
    end
  end

  assign isE0_s     = byteValid_r && (byte_r == 8'hE0);
  assign isF0_s     = byteValid_r && (byte_r == 8'hF0);
  assign isKey_s    = byteValid_r && !isE0_s && !isF0_s;
  assign pushReq_s  = isKey_s && !suppress_s;
  assign pushData_s = {byte_r, pendE0_r, pendF0_r};

  // Modifier updates: make sets, break clears; E0 12/E0 59 are fake shifts
  always_comb begin
    lShiftNext_s = lShift_r;
    rShiftNext_s = rShift_r;
    lCtrlNext_s  = lCtrl_r;
    rCtrlNext_s  = rCtrl_r;
    lAltNext_s   = lAlt_r;
    rAltNext_s   = rAlt_r;
    if (isKey_s) begin
      case ({pendE0_r, byte_r})
        9'h012:  lShiftNext_s = ~pendF0_r;
        9'h059:  rShiftNext_s = ~pendF0_r;
        9'h014:  lCtrlNext_s  = ~pendF0_r;
        9'h114:  rCtrlNext_s  = ~pendF0_r;
        9'h011:  lAltNext_s   = ~pendF0_r;
        9'h111:  rAltNext_s   = ~pendF0_r;
        default: lShiftNext_s = lShift_r;
      endcase
    end else begin
      lShiftNext_s = lShift_r;
    end
  end

  // Prefix and modifier registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendE0_r <= 1'b0; pendF0_r <= 1'b0;
      lShift_r <= 1'b0; rShift_r <= 1'b0; lCtrl_r <= 1'b0;
      rCtrl_r  <= 1'b0; lAlt_r   <= 1'b0; rAlt_r  <= 1'b0;
      shift_r  <= 1'b0; ctrl_r   <= 1'b0; alt_r   <= 1'b0;
    end else begin
      if (isE0_s)       pendE0_r <= 1'b1;
      else if (isKey_s) pendE0_r <= 1'b0;
      if (isF0_s)       pendF0_r <= 1'b1;
      else if (isKey_s) pendF0_r <= 1'b0;
      lShift_r <= lShiftNext_s; rShift_r <= rShiftNext_s;
      lCtrl_r  <= lCtrlNext_s;  rCtrl_r  <= rCtrlNext_s;
      lAlt_r   <= lAltNext_s;   rAlt_r   <= rAltNext_s;
      shift_r  <= lShiftNext_s | rShiftNext_s;
      ctrl_r   <= lCtrlNext_s | rCtrlNext_s;
      alt_r    <= lAltNext_s | rAltNext_s;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       lastValid_r, lastE0_r;
  logic [7:0] lastCode_r;

  assign suppress_s = isKey_s && !pendF0_r && lastValid_r &&
                      (lastCode_r == byte_r) && (lastE0_r == pendE0_r);

  // Remember the last make so auto-repeats of it are swallowed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastValid_r <= 1'b0;
      lastE0_r    <= 1'b0;
      lastCode_r  <= 8'd0;
    end else if (isKey_s) begin
      if (pendF0_r) begin
        lastValid_r <= 1'b0;
      end else begin
        lastValid_r <= 1'b1;
        lastE0_r    <= pendE0_r;
        lastCode_r  <= byte_r;
      end
    end
  end
`else
  assign suppress_s = 1'b0;
`endif

  assign pop_s       = evValid_r & evReady;
  assign full_s      = (count_r == DEPTH_C);
  assign pushOk_s    = pushReq_s && (!full_s || pop_s);
  assign ovfSet_s    = pushReq_s && full_s && !pop_s;
  assign countNext_s = count_r + (AW + 1)'(pushOk_s) - (AW + 1)'(pop_s);
  assign rdNext_s    = rdPtr_r + AW'(pop_s);

  // Head entry for next cycle; a push into an emptying FIFO bypasses memory
  always_comb begin
    headNext_s = mem_r[rdNext_s];
    if (pushOk_s && (count_r == (AW + 1)'(pop_s))) headNext_s = pushData_s;
    else                                           headNext_s = mem_r[rdNext_s];
  end

  // Event FIFO storage, pointers and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      count_r    <= '0;
      evValid_r  <= 1'b0;
      head_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (pushOk_s) begin
        mem_r[wrPtr_r] <= pushData_s;
        wrPtr_r        <= wrPtr_r + AW'(1);
      end
      rdPtr_r    <= rdNext_s;
      count_r    <= countNext_s;
      evValid_r  <= (countNext_s != '0);
      head_r     <= headNext_s;
      overflow_r <= overflow_r | ovfSet_s;
    end
  end

  assign evValid    = evValid_r;
  assign evCode     = head_r[9:2];
  assign evExtended = head_r[1];
  assign evBreak    = head_r[0];
  assign frameError = frameErr_r;
  assign overflow   = overflow_r;
  assign shift      = shift_r;
  assign ctrl       = ctrl_r;
  assign alt        = alt_r;
  assign debugE0    = pendE0_r;
  assign debugF0    = pendF0_r;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Self-checking bench for ps2_keyboard_ctrl: directed scenarios plus random
// key traffic checked against a scancode-level reference model.
module tb_ps2_keyboard_ctrl;
  localparam int TO = 200;

  logic       clk = 1'b0, reset = 1'b0, ps2Clk = 1'b1, ps2Data = 1'b1, evReady = 1'b0;
  logic       evValid, evExtended, evBreak, frameError, overflow;
  logic       shift, ctrl, alt, debugE0, debugF0;
  logic [7:0] evCode;

  always #5 clk = ~clk;

  ps2_keyboard_ctrl #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .evValid(evValid), .evReady(evReady), .evCode(evCode),
    .evExtended(evExtended), .evBreak(evBreak), .frameError(frameError),
    .overflow(overflow), .shift(shift), .ctrl(ctrl), .alt(alt),
    .debugE0(debugE0), .debugF0(debugF0)
  );

  typedef struct packed {logic [7:0] code; logic ext; logic brk;} ev_t;

  int   cmpCnt = 0, errCnt = 0, errPulses = 0, popCnt = 0;
  ev_t  expQ[$];
  bit   mE0, mF0, mLS, mRS, mLC, mRC, mLA, mRA, mOvf, lastV;
  logic [8:0] lastKey;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted event must match the model's queue head
  always @(negedge clk) begin
    if (frameError === 1'b1) errPulses++;
    if (evValid === 1'b1 && evReady === 1'b1) begin
      popCnt++;
      cmpCnt++;
      assert (expQ.size() > 0) else begin
        errCnt++;
        $error("FAIL event_unexpected: observed %0h/%0b/%0b expected no event", evCode, evExtended, evBreak);
      end
      if (expQ.size() > 0) chk("event", {22'd0, evCode, evExtended, evBreak}, {22'd0, expQ.pop_front()});
    end
  end

  task automatic modelReset();
    expQ.delete();
    {mE0, mF0, mLS, mRS, mLC, mRC, mLA, mRA, mOvf, lastV} = '0;
    lastKey = '0;
  endtask

  task automatic modelByte(input logic [7:0] b);
    bit supp = 1'b0;
    if (b == 8'hE0) mE0 = 1'b1;
    else if (b == 8'hF0) mF0 = 1'b1;
    else begin
      if (!mE0 && b == 8'h12) mLS = !mF0;
      if (!mE0 && b == 8'h59) mRS = !mF0;
      if (b == 8'h14) begin if (mE0) mRC = !mF0; else mLC = !mF0; end
      if (b == 8'h11) begin if (mE0) mRA = !mF0; else mLA = !mF0; end
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (mF0) lastV = 1'b0;
      else if (lastV && lastKey == {b, mE0}) supp = 1'b1;
      else begin lastV = 1'b1; lastKey = {b, mE0}; end
`endif
      if (!supp) begin
        if (expQ.size() < 4) expQ.push_back({b, mE0, mF0});
        else mOvf = 1'b1;
      end
      mE0 = 1'b0;
      mF0 = 1'b0;
    end
  endtask

  task automatic sendBit(input logic b);
    @(posedge clk); #1 ps2Data = b;
    repeat (3) @(posedge clk);
    #1 ps2Clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic badStop);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~^b ^ badPar);
    sendBit(~badStop);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag);
    chk({tag, "_shift"}, 32'(shift), 32'(mLS | mRS));
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(mLC | mRC));
    chk({tag, "_alt"}, 32'(alt), 32'(mLA | mRA));
    chk({tag, "_debugE0"}, 32'(debugE0), 32'(mE0));
    chk({tag, "_debugF0"}, 32'(debugF0), 32'(mF0));
    chk({tag, "_overflow"}, 32'(overflow), 32'(mOvf));
  endtask

  task automatic sendKey(input logic [7:0] b, input string tag);
    int e0 = errPulses;
    modelByte(b);
    sendFrame(b, 1'b0, 1'b0);
    checkState(tag);
    chk({tag, "_noerr"}, 32'(errPulses), 32'(e0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, p0;
    logic [7:0] b;
    modelReset();
    @(negedge clk);
    chk("rst_evValid", 32'(evValid), 32'd0);
    chk("rst_frameError", 32'(frameError), 32'd0);
    chk("rst_evCode", 32'(evCode), 32'd0);
    checkState("rst");
    @(posedge clk); #1 reset = 1'b1;
    evReady = 1'b1;
    repeat (4) @(posedge clk);

    // 1: latency of a single good frame
    e0 = errPulses;
    modelByte(8'h1C);
    sendBit(1'b0);
    b = 8'h1C;
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~^b);
    @(posedge clk); #1 ps2Data = 1'b1;
    repeat (3) @(posedge clk);
    #1 ps2Clk = 1'b0;
    @(negedge clk) chk("lat_fall", 32'(evValid), 32'd0);
    @(negedge clk) chk("lat_plus1", 32'(evValid), 32'd0);
    @(negedge clk) chk("lat_plus2", 32'(evValid), 32'd1);
    chk("lat_code", 32'(evCode), 32'h1C);
    @(posedge clk); #1 ps2Clk = 1'b1;
    repeat (6) @(posedge clk);
    chk("t1_noerr", 32'(errPulses), 32'(e0));

    // 2: prefix folding
    sendKey(8'hE0, "t2_e0");
    sendKey(8'hF0, "t2_f0");
    sendKey(8'h75, "t2_75");

    // 3: modifiers
    sendKey(8'h12, "t3_lsh");
    sendKey(8'hF0, "t3_f0");
    sendKey(8'h12, "t3_lsh_brk");
    sendKey(8'hE0, "t3_e0");
    sendKey(8'h12, "t3_fake");
    sendKey(8'hE0, "t3_e0b");
    sendKey(8'h14, "t3_rctrl");
    sendKey(8'h11, "t3_lalt");

    // 4: parity, stop and timeout errors
    e0 = errPulses;
    sendFrame(8'h1C, 1'b1, 1'b0);
    chk("t4_parity_err", 32'(errPulses), 32'(e0 + 1));
    sendFrame(8'h1C, 1'b0, 1'b1);
    chk("t4_stop_err", 32'(errPulses), 32'(e0 + 2));
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    repeat (TO + 20) @(posedge clk);
    #1 chk("t4_timeout_err", 32'(errPulses), 32'(e0 + 3));
    checkState("t4_after");
    sendKey(8'h1C, "t4_good");

    // 5: overflow with a stalled consumer
    evReady = 1'b0;
    sendKey(8'h32, "t5_a");
    sendKey(8'h21, "t5_b");
    sendKey(8'h23, "t5_c");
    sendKey(8'h24, "t5_d");
    sendKey(8'h2B, "t5_e");
    p0 = popCnt;
    @(posedge clk); #1 evReady = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("t5_drained", 32'(popCnt - p0), 32'd4);
    chk("t5_model_empty", 32'(expQ.size()), 32'd0);

    // 6: repeated makes
    p0 = popCnt;
    sendKey(8'h1C, "t6_m1");
    sendKey(8'h1C, "t6_m2");
    sendKey(8'h1C, "t6_m3");
    sendKey(8'hF0, "t6_f0");
    sendKey(8'h1C, "t6_brk");
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t6_events", 32'(popCnt - p0), 32'd2);
`else
    chk("t6_events", 32'(popCnt - p0), 32'd4);
`endif

    // Reset mid-frame with a buffered event
    evReady = 1'b0;
    sendKey(8'h4D, "rst_mid_key");
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    #1 reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_evValid", 32'(evValid), 32'd0);
    checkState("rst_mid");
    evReady = 1'b1;

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h12;
        3: b = 8'h59;
        4: b = 8'h14;
        5: b = 8'h11;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        e0 = errPulses;
        sendFrame(b, 1'b1, 1'b0);
        chk("rnd_bad", 32'(errPulses), 32'(e0 + 1));
      end else begin
        sendKey(b, "rnd");
      end
    end
    repeat (20) @(posedge clk);
    #1 chk("final_model_empty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end
endmodule
